period_meter: RTL and testbench

- Receiving end of the divided-clock interface: takes a slow toggling signal (divided clock or control toggle) and recovers its period and high time, both in cycles of the fast system clock.
- Sits next to the counter/display logic. Used to check divider outputs and to measure external slow signals.
- Results are delivered over a valid/ack handshake, with sticky timeout and overrun flags.

---
 rtl/clkdiv_pkg.sv | 16 +
 rtl/period_meter_if.sv | 38 +++
 rtl/period_meter_edge_sync.sv | 33 +++
 rtl/period_meter.sv | 128 ++++++++++++
 tb/tb_period_meter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider / period-meter family.
//   state_t          : period meter FSM states
//   SYNC_STAGES      : synchronizer depth for asynchronous inputs
//   DEFAULT_CLK_FREQ : system clock frequency in Hz shared with the divider
package clkdiv_pkg;

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

endpackage

// File: rtl/period_meter_if.sv
// Result channel of the period meter.
//   meas_valid : result available and held stable (producer -> consumer)
//   period     : clk cycles between consecutive rising edges
//   high_time  : clk cycles from a rising edge to the following falling edge
//   timeout    : sticky, no rising edge seen within the timeout window
//   overrun    : sticky, an unacknowledged result was overwritten
//   meas_ack   : consumer acknowledges the current result (consumer -> producer)
// Modports: master = producer (period_meter), slave = consumer.
interface period_meter_if #(
  parameter int CNT_W = 32
);

  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             timeout;
  logic             overrun;
  logic             meas_ack;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    output timeout,
    output overrun,
    input  meas_ack
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    input  timeout,
    input  overrun,
    output meas_ack
  );

endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: brings an asynchronous level into the clk domain and flags its
// edges.  A SYNC_STAGES-deep synchronizer is followed by one history flop;
// rise/fall are single-cycle pulses derived from the last two stages.
//   clk      : system clock
//   rst_n_a  : asynchronous active-low reset, clears all flops
//   async_in : asynchronous level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module edge_sync
  import clkdiv_pkg::*;
(
  input  logic clk,
  input  logic rst_n_a,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  // [0 .. SYNC_STAGES-1] synchronizer, [SYNC_STAGES] history
  logic [SYNC_STAGES:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-1:0], async_in};
    end
  end

  assign rise =  sync_reg[SYNC_STAGES-1] & ~sync_reg[SYNC_STAGES];
  assign fall = ~sync_reg[SYNC_STAGES-1] &  sync_reg[SYNC_STAGES];

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow toggling signal in
// clk cycles and hands results out over a valid/ack channel with sticky
// timeout and overrun flags.
//   clk      : system clock
//   rst_n_a  : asynchronous active-low reset
//   sig_in   : measured signal, asynchronous to clk
//   clr      : synchronous clear of measurement state, results and flags
//   meas     : result channel (period_meter_if.master)
// Parameters:
//   CLK_FREQ : system clock in Hz, only used to derive the default TIMEOUT
//   CNT_W    : counter / result width
//   TIMEOUT  : cycles without a rising edge before a measurement is dropped,
//              2 <= TIMEOUT <= 2**CNT_W-1
module period_meter
  import clkdiv_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int          CNT_W    = 32,
  parameter int unsigned TIMEOUT  = CLK_FREQ
) (
  input  logic           clk,
  input  logic           rst_n_a,
  input  logic           sig_in,
  input  logic           clr,
  period_meter_if.master meas
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic             rise;
  logic             fall;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_time_reg;
  logic             valid_reg;
  logic             timeout_reg;
  logic             overrun_reg;
  logic             new_result;

  edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n_a  (rst_n_a),
    .async_in (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  // cnt counts cycles since the last rise minus one, so cnt+1 is the
  // distance in cycles to the current edge.  cnt stays below TIMEOUT, so
  // the increment cannot wrap.
  assign cnt_inc    = cnt_reg + CNT_W'(1);
  assign new_result = (state_reg == MEASURE) && rise;

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state_reg     <= WAIT_EDGE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (clr) begin
      state_reg     <= WAIT_EDGE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_EDGE: begin
          // first rise only arms the measurement
          cnt_reg <= '0;
          if (rise) begin
            state_reg <= MEASURE;
          end
        end
        MEASURE: begin
          if (fall) begin
            hi_reg <= cnt_inc;
          end
          if (rise) begin
            // a rise on the last allowed cycle still wins over timeout
            cnt_reg       <= '0;
            period_reg    <= cnt_inc;
            high_time_reg <= hi_reg;
            timeout_reg   <= 1'b0;
          end else if (cnt_reg == CNT_MAX) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b1;
            state_reg   <= WAIT_EDGE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= WAIT_EDGE;
          cnt_reg   <= '0;
        end
      endcase

      // handshake: a new result always lands; ack only retires a result
      // when nothing new arrives in the same cycle
      if (new_result) begin
        valid_reg <= 1'b1;
        if (valid_reg && !meas.meas_ack) begin
          overrun_reg <= 1'b1;
        end
      end else if (meas.meas_ack) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign meas.meas_valid = valid_reg;
  assign meas.period     = period_reg;
  assign meas.high_time  = high_time_reg;
  assign meas.timeout    = timeout_reg;
  assign meas.overrun    = overrun_reg;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter (CNT_W=16, TIMEOUT=100).  A
// timestamp-based reference model predicts all outputs every cycle; directed
// scenarios add literal expectations, then a randomized phase follows.
module tb_period_meter;
  import clkdiv_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic clk     = 1'b0;
  logic rst_n_a = 1'b1;
  logic sig_in  = 1'b0;
  logic clr     = 1'b0;
  int   ack_mode = 1;  // 0: hold 0, 1: hold 1, 2: random, 3: manual

  int checks = 0;
  int errors = 0;

  period_meter_if #(.CNT_W(CNT_W)) mif ();

  period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n_a (rst_n_a),
    .sig_in  (sig_in),
    .clr     (clr),
    .meas    (mif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (timestamps of detected edges) --------
  bit   hist[3];
  int   cyc = 0, last_rise = 0, last_fall = 0;
  bit   armed = 0;
  logic e_valid = 0, e_to = 0, e_ov = 0;
  int   e_per = 0, e_hi = 0;

  always @(posedge clk or negedge rst_n_a) begin : model
    bit r, f, got;
    if (!rst_n_a) begin
      hist = '{default: 1'b0};
      cyc = 0; armed = 0; last_rise = 0; last_fall = 0;
      e_valid = 0; e_to = 0; e_ov = 0; e_per = 0; e_hi = 0;
    end else begin
      cyc++;
      got = 0;
      // edges become visible to the DUT's logic a fixed two samples late
      r =  hist[1] && !hist[2];
      f = !hist[1] &&  hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = sig_in;
      if (clr) begin
        armed = 0; e_valid = 0; e_to = 0; e_ov = 0; e_per = 0; e_hi = 0;
      end else begin
        if (armed && r) begin
          if (e_valid && !mif.meas_ack) e_ov = 1;
          e_valid = 1;
          e_per = cyc - last_rise;
          e_hi  = last_fall - last_rise;
          e_to  = 0;
          last_rise = cyc;
          got = 1;
        end else if (armed && (cyc - last_rise == TIMEOUT)) begin
          e_to = 1;
          armed = 0;
        end else if (!armed && r) begin
          armed = 1;
          last_rise = cyc;
        end
        if (!got && mif.meas_ack && e_valid) e_valid = 0;
        if (f && armed) last_fall = cyc;
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("meas_valid", 32'(mif.meas_valid), 32'(e_valid));
      check("period",     32'(mif.period),     32'(e_per));
      check("high_time",  32'(mif.high_time),  32'(e_hi));
      check("timeout",    32'(mif.timeout),    32'(e_to));
      check("overrun",    32'(mif.overrun),    32'(e_ov));
    end
  end

  // record the last result presented by the DUT
  int seen_n = 0, seen_per = 0, seen_hi = 0;
  always @(negedge clk) begin
    if (mif.meas_valid === 1'b1) begin
      seen_n++;
      seen_per = 32'(mif.period);
      seen_hi  = 32'(mif.high_time);
    end
  end

  // ack driver
  initial begin
    mif.meas_ack = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      case (ack_mode)
        0: mif.meas_ack = 1'b0;
        1: mif.meas_ack = 1'b1;
        2: mif.meas_ack = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      step(h);
      sig_in = 1'b0;
      step(l);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(mif.meas_valid), 0);
    check({tag, "_period"},  32'(mif.period),     0);
    check({tag, "_high"},    32'(mif.high_time),  0);
    check({tag, "_timeout"}, 32'(mif.timeout),    0);
    check({tag, "_overrun"}, 32'(mif.overrun),    0);
  endtask

  initial begin
    int n0, h, l, sel;
    // asynchronous reset, outputs must be zero before any clock edge
    #1 rst_n_a = 1'b0;
    #1 check_all_zero("reset");
    step(3);
    rst_n_a = 1'b1;
    step(2);

    // 4 high / 6 low, ack held
    ack_mode = 1;
    n0 = seen_n;
    wave(4, 6, 4);
    check("t1_results", 32'(seen_n - n0), 3);
    check("t1_period",  32'(seen_per), 10);
    check("t1_high",    32'(seen_hi), 4);
    check("t1_overrun", 32'(mif.overrun), 0);

    // divider output toggling every 5 cycles
    wave(5, 5, 4);
    check("t2_period", 32'(seen_per), 10);
    check("t2_high",   32'(seen_hi), 5);

    // signal stops low: timeout, then recovery
    step(110);
    check("t3_timeout", 32'(mif.timeout), 1);
    check("t3_period",  32'(mif.period), 10);
    check("t3_high",    32'(mif.high_time), 5);
    n0 = seen_n;
    wave(5, 5, 3);
    check("t3_results",    32'(seen_n - n0), 2);
    check("t3_timeout_cl", 32'(mif.timeout), 0);
    check("t3_period2",    32'(seen_per), 10);

    // overrun without ack
    pulse_clr();
    ack_mode = 0;
    wave(5, 5, 3);
    check("t4_overrun", 32'(mif.overrun), 1);
    check("t4_valid",   32'(mif.meas_valid), 1);
    check("t4_period",  32'(mif.period), 10);
    ack_mode = 3;
    mif.meas_ack = 1'b1;
    step(1);
    mif.meas_ack = 1'b0;
    check("t4_valid_ack",   32'(mif.meas_valid), 0);
    check("t4_overrun_ack", 32'(mif.overrun), 1);
    pulse_clr();
    check_all_zero("t4_clr");

    // period exactly TIMEOUT yields a result, TIMEOUT+1 times out
    ack_mode = 0;
    wave(50, 50, 3);
    check("t5_period",  32'(mif.period), 100);
    check("t5_valid",   32'(mif.meas_valid), 1);
    check("t5_timeout", 32'(mif.timeout), 0);
    pulse_clr();
    wave(50, 51, 3);
    check("t5_timeout101", 32'(mif.timeout), 1);
    check("t5_valid101",   32'(mif.meas_valid), 0);

    // randomized phase with a mid-period asynchronous reset
    ack_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        sig_in = 1'b1;
        step(3);
        @(posedge clk);
        #2 rst_n_a = 1'b0;
        #1 check_all_zero("async_rst");
        step(3);
        #2 rst_n_a = 1'b1;
        @(posedge clk);
        #3;
        n0 = seen_n;
        sig_in = 1'b0;
        step(4);
        check("rst_no_result", 32'(seen_n - n0), 0);
      end
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        pulse_clr();
      end else if (sel == 1) begin
        step($urandom_range(90, 130));
      end else begin
        h = $urandom_range(1, 20);
        l = $urandom_range(1, 20);
        wave(h, l, $urandom_range(1, 4));
      end
    end
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
